// File: rtl/regfile_wb_scoreboard.sv
// regfile_wb_scoreboard
//   Sequences the shared 32x32 register file. The block arbitrates the single write
//   port between the single-cycle ALU writeback and the long-latency (LSU/mul)
//   writeback. It also keeps a per-register busy scoreboard, which stalls issue on
//   RAW/WAW hazards against long-latency results that are still pending.
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   issue_*               decode/issue handshake and operand/destination fields
//   alu_wb_*              ALU writeback request (valid/ready, rd, data)
//   lsu_wb_*              long-latency writeback request (valid/ready, rd, data)
//   rf_we/rf_rd/rf_data   register file write port
//   busy_vec              scoreboard (bit i = x[i] awaiting a long result)
//   outstanding           number of long writes in flight
//   wb_err                sticky flag: LSU wrote a non-busy register or x0
module regfile_wb_scoreboard #(
  parameter int MAX_OUT  = 4,
  parameter int MAX_WAIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  input  logic [4:0]  issue_rd,
  input  logic        issue_rd_we,
  input  logic        issue_long,
  input  logic        alu_wb_valid,
  output logic        alu_wb_ready,
  input  logic [4:0]  alu_wb_rd,
  input  logic [31:0] alu_wb_data,
  input  logic        lsu_wb_valid,
  output logic        lsu_wb_ready,
  input  logic [4:0]  lsu_wb_rd,
  input  logic [31:0] lsu_wb_data,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_data,
  output logic [31:0] busy_vec,
  output logic [4:0]  outstanding,
  output logic        wb_err
);

  localparam int WCW = $clog2(MAX_WAIT + 1);

  logic [WCW-1:0] waitCnt_q, waitCnt_d;
  logic [31:0]    busy_q, busy_d;
  logic [4:0]     outstanding_q, outstanding_d;
  logic           wbErr_q, wbErr_d;

  logic        lsuPri, grantLsu, grantAlu;
  logic        clr, set, lsuToBusy;
  logic [31:0] clrMask, setMask, busyEff;
  logic        stall;

  // Write-port arbitration. Every grant and ready is qualified with reset, so
  // nothing is written and nothing issues while reset is held low.
  always_comb begin
    lsuPri   = (waitCnt_q == WCW'(MAX_WAIT));
    grantLsu = reset & lsu_wb_valid & (lsuPri | ~alu_wb_valid);
    grantAlu = reset & alu_wb_valid & ~(lsuPri & lsu_wb_valid);
    alu_wb_ready = grantAlu;
    lsu_wb_ready = grantLsu;
    rf_we   = grantLsu | grantAlu;
    rf_rd   = 5'd0;
    rf_data = 32'd0;
    if (grantLsu) begin
      rf_rd   = lsu_wb_rd;
      rf_data = lsu_wb_data;
    end else if (grantAlu) begin
      rf_rd   = alu_wb_rd;
      rf_data = alu_wb_data;
    end
  end

  // Scoreboard update and hazard check. busyEff already reflects this cycle's LSU
  // retire, because the regfile forwards the written value to same-cycle reads.
  // The "full" check uses the registered count on purpose, so a same-cycle retire
  // does not free a slot.
  always_comb begin
    clr       = grantLsu & (lsu_wb_rd != 5'd0);
    lsuToBusy = clr & busy_q[lsu_wb_rd];
    clrMask   = clr ? (32'd1 << lsu_wb_rd) : 32'd0;
    busyEff   = busy_q & ~clrMask;
    stall = 1'b0;
    if (issue_rs1 != 5'd0 && busyEff[issue_rs1]) stall = 1'b1;
    if (issue_rs2 != 5'd0 && busyEff[issue_rs2]) stall = 1'b1;
    if (issue_rd_we && issue_rd != 5'd0 && busyEff[issue_rd]) stall = 1'b1;
    if (issue_long && issue_rd_we && issue_rd != 5'd0 &&
        outstanding_q == 5'(MAX_OUT)) stall = 1'b1;
    issue_ready = reset & ~stall;
    set     = issue_valid & issue_ready & issue_long & issue_rd_we & (issue_rd != 5'd0);
    setMask = set ? (32'd1 << issue_rd) : 32'd0;
    busy_d  = ((busy_q & ~clrMask) | setMask) & ~32'd1;
    outstanding_d = outstanding_q;
    case ({set, lsuToBusy})
      2'b10:   outstanding_d = outstanding_q + 5'd1;
      2'b01:   outstanding_d = outstanding_q - 5'd1;
      default: outstanding_d = outstanding_q;
    endcase
    wbErr_d = wbErr_q | (grantLsu & ~lsuToBusy);
  end

  // Starvation counter. It counts the consecutive cycles in which the LSU is
  // waiting without a grant, and it saturates at the value that gives the LSU priority.
  always_comb begin
    waitCnt_d = '0;
    if (lsu_wb_valid && !grantLsu)
      waitCnt_d = lsuPri ? waitCnt_q : waitCnt_q + 1'b1;
  end

  // State registers. An asynchronous reset drops all pending long-latency state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waitCnt_q     <= '0;
      busy_q        <= 32'd0;
      outstanding_q <= 5'd0;
      wbErr_q       <= 1'b0;
    end else begin
      waitCnt_q     <= waitCnt_d;
      busy_q        <= busy_d;
      outstanding_q <= outstanding_d;
      wbErr_q       <= wbErr_d;
    end
  end

  assign busy_vec    = busy_q;
  assign outstanding = outstanding_q;
  assign wb_err      = wbErr_q;

endmodule
